// File: rtl/axi_master_arbiter_pkg.sv
// Shared widths, state/owner encodings and command record for the two-port
// arbiter that fronts the axi_master bridge.
package axi_master_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  typedef enum logic {
    OWNER_P0 = 1'b0,
    OWNER_P1 = 1'b1
  } owner_t;

  typedef struct packed {
    logic                  rd0_wr1;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } cmd_t;

endpackage

// File: rtl/axi_master_arbiter_rr_arb2.sv
// Two-input arbiter: one-hot grant from the requests and the last-grant pointer
// kept by the parent. Purely combinational.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_p1,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie, port 0 wins under fixed priority or when port 1 went last
      2'b11:   gnt = (FIXED_PRIO || last_p1) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one axi_master bridge between the fetch (port 0) and LSU (port 1)
// requesters; one command in flight, result routed back to the owning port.
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  p0_req,
  input  logic                  p0_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [STRB_WIDTH-1:0] p0_strb,
  output logic                  p0_gnt,
  output logic                  p0_done,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic [1:0]            p0_resp,
  input  logic                  p1_req,
  input  logic                  p1_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [STRB_WIDTH-1:0] p1_strb,
  output logic                  p1_gnt,
  output logic                  p1_done,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [1:0]            p1_resp,
  output logic                  M_access,
  output logic                  M_rd0_wr1,
  output logic [ADDR_WIDTH-1:0] M_addr,
  output logic [DATA_WIDTH-1:0] M_write_data,
  output logic [STRB_WIDTH-1:0] M_write_strobe,
  input  logic                  ready_M,
  input  logic [DATA_WIDTH-1:0] read_data_M,
  input  logic                  read_data_valid_M,
  input  logic [1:0]            resp_M
);

  arb_state_t            state, state_nxt;
  owner_t                owner;
  logic                  last_p1;
  cmd_t                  cmd, p0_cmd, p1_cmd;
  logic [DATA_WIDTH-1:0] res_rdata;
  logic [1:0]            res_resp;
  logic [1:0]            req, win;
  logic                  take;

  // The result register samples every busy cycle, so the valid strobe is not needed
  logic unused_rvalid;
  assign unused_rvalid = read_data_valid_M;

  assign req    = {p1_req, p0_req};
  assign p0_cmd = '{rd0_wr1: p0_rd0_wr1, addr: p0_addr, wdata: p0_wdata, strb: p0_strb};
  assign p1_cmd = '{rd0_wr1: p1_rd0_wr1, addr: p1_addr, wdata: p1_wdata, strb: p1_strb};
  assign take   = (state == ST_IDLE) && ready_M && (|req);

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_rr_arb2 (
    .req     (req),
    .last_p1 (last_p1),
    .gnt     (win)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (take) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (ready_M) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      owner     <= OWNER_P0;
      last_p1   <= 1'b1;
      cmd       <= '0;
      res_rdata <= '0;
      res_resp  <= '0;
    end else begin
      if (take) begin
        owner   <= win[1] ? OWNER_P1 : OWNER_P0;
        last_p1 <= win[1];
        cmd     <= win[1] ? p1_cmd : p0_cmd;
      end
      // Last low-ready cycle is the bridge's RVALID/BVALID beat
      if (state == ST_WAIT && !ready_M) begin
        res_rdata <= read_data_M;
        res_resp  <= resp_M;
      end
    end
  end

  always_comb begin
    M_access = 1'b0;
    p0_gnt   = 1'b0;
    p1_gnt   = 1'b0;
    p0_done  = 1'b0;
    p1_done  = 1'b0;
    p0_rdata = '0;
    p1_rdata = '0;
    p0_resp  = '0;
    p1_resp  = '0;
    case (state)
      ST_ISSUE: begin
        M_access = 1'b1;
        p0_gnt   = (owner == OWNER_P0);
        p1_gnt   = (owner == OWNER_P1);
      end
      ST_DONE: begin
        if (owner == OWNER_P0) begin
          p0_done  = 1'b1;
          p0_rdata = res_rdata;
          p0_resp  = res_resp;
        end else begin
          p1_done  = 1'b1;
          p1_rdata = res_rdata;
          p1_resp  = res_resp;
        end
      end
      default: ;
    endcase
  end

  assign M_rd0_wr1      = cmd.rd0_wr1;
  assign M_addr         = cmd.addr;
  assign M_write_data   = cmd.wdata;
  assign M_write_strobe = cmd.strb;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: round-robin and fixed-priority instances, each
// with its own simple bridge model; completions checked against a scoreboard.
module tb_axi_master_arbiter;

  logic        ACLK;
  logic        ARESETn;
  logic        use_fp;
  logic        hold_busy;
  logic [31:0] bridge_rdata;
  logic [1:0]  bridge_resp;

  logic        p0_req, p0_rd0_wr1, p1_req, p1_rd0_wr1;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_strb, p1_strb;

  logic [1:0]  p0_gnt_w, p1_gnt_w, p0_done_w, p1_done_w;
  logic [31:0] p0_rdata_w [2];
  logic [31:0] p1_rdata_w [2];
  logic [1:0]  p0_resp_w [2];
  logic [1:0]  p1_resp_w [2];
  logic [1:0]  m_access, m_rw, ready_M, rdv_M;
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_strb [2];
  logic [31:0] rd_M [2];
  logic [1:0]  resp_M [2];

  logic [1:0]  rdy_r, rd_q, last_beat;
  int unsigned cnt [2];

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  for (genvar d = 0; d < 2; d++) begin : g_dut
    axi_master_arbiter #(.FIXED_PRIO(d == 1)) dut (
      .ACLK              (ACLK),
      .ARESETn           (ARESETn),
      .p0_req            (p0_req && (use_fp == (d == 1))),
      .p0_rd0_wr1        (p0_rd0_wr1),
      .p0_addr           (p0_addr),
      .p0_wdata          (p0_wdata),
      .p0_strb           (p0_strb),
      .p0_gnt            (p0_gnt_w[d]),
      .p0_done           (p0_done_w[d]),
      .p0_rdata          (p0_rdata_w[d]),
      .p0_resp           (p0_resp_w[d]),
      .p1_req            (p1_req && (use_fp == (d == 1))),
      .p1_rd0_wr1        (p1_rd0_wr1),
      .p1_addr           (p1_addr),
      .p1_wdata          (p1_wdata),
      .p1_strb           (p1_strb),
      .p1_gnt            (p1_gnt_w[d]),
      .p1_done           (p1_done_w[d]),
      .p1_rdata          (p1_rdata_w[d]),
      .p1_resp           (p1_resp_w[d]),
      .M_access          (m_access[d]),
      .M_rd0_wr1         (m_rw[d]),
      .M_addr            (m_addr[d]),
      .M_write_data      (m_wdata[d]),
      .M_write_strobe    (m_strb[d]),
      .ready_M           (ready_M[d]),
      .read_data_M       (rd_M[d]),
      .read_data_valid_M (rdv_M[d]),
      .resp_M            (resp_M[d])
    );
  end

  // Bridge model: ready drops for 3 cycles (write) or 2 (read); data/resp on the last low cycle
  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int b = 0; b < 2; b++) begin
        rdy_r[b] <= 1'b1;
        rd_q[b]  <= 1'b0;
        cnt[b]   <= 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (ready_M[b] && m_access[b]) begin
          rdy_r[b] <= 1'b0;
          rd_q[b]  <= !m_rw[b];
          cnt[b]   <= m_rw[b] ? 3 : 2;
        end else if (cnt[b] != 0) begin
          if (cnt[b] == 1) rdy_r[b] <= 1'b1;
          cnt[b] <= cnt[b] - 1;
        end
      end
    end
  end

  always_comb begin
    ready_M   = '0;
    rdv_M     = '0;
    last_beat = '0;
    for (int b = 0; b < 2; b++) begin
      ready_M[b]   = rdy_r[b] && !hold_busy;
      last_beat[b] = !rdy_r[b] && (cnt[b] == 1);
      rdv_M[b]     = last_beat[b] && rd_q[b];
      rd_M[b]      = rdv_M[b] ? bridge_rdata : 32'h0;
      resp_M[b]    = last_beat[b] ? bridge_resp : 2'b00;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion monitor for the round-robin instance
  always @(negedge ACLK) begin
    if (ARESETn && (p0_done_w[0] || p1_done_w[0])) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {p1_done_w[0], p0_done_w[0]}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("done_port", {p1_done_w[0], p0_done_w[0]}, e.port ? 2'b10 : 2'b01);
        chk("done_rdata", e.port ? p1_rdata_w[0] : p0_rdata_w[0], e.rdata);
        chk("done_resp", e.port ? p1_resp_w[0] : p0_resp_w[0], e.resp);
      end
    end
  end

  task automatic wait_gnt(input int d, input logic [1:0] exp, input string tag);
    int n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!(p0_gnt_w[d] || p1_gnt_w[d]) && n < 50);
    chk(tag, {p1_gnt_w[d], p0_gnt_w[d]}, exp);
  endtask

  task automatic wait_done(input int d, input logic [1:0] exp, input string tag);
    int n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!(p0_done_w[d] || p1_done_w[d]) && n < 50);
    chk(tag, {p1_done_w[d], p0_done_w[d]}, exp);
  endtask

  task automatic push(input bit port, input logic [31:0] rdata, input logic [1:0] resp);
    exp_t x;
    x.port = port;
    x.rdata = rdata;
    x.resp = resp;
    sb.push_back(x);
  endtask

  initial begin
    int n;
    bit seen;
    ARESETn = 1'b0; use_fp = 1'b0; hold_busy = 1'b0;
    bridge_rdata = 32'h0; bridge_resp = 2'b00;
    p0_req = 0; p0_rd0_wr1 = 0; p0_addr = 0; p0_wdata = 0; p0_strb = 0;
    p1_req = 0; p1_rd0_wr1 = 0; p1_addr = 0; p1_wdata = 0; p1_strb = 0;
    repeat (3) @(negedge ACLK);
    chk("rst_outputs", {p0_gnt_w[0], p1_gnt_w[0], p0_done_w[0], p1_done_w[0], m_access[0], m_rw[0]}, 6'h0);
    chk("rst_addr_data", {m_addr[0], m_wdata[0]}, 64'h0);
    chk("rst_strb_resp", {m_strb[0], p0_resp_w[0], p1_resp_w[0]}, 8'h0);
    chk("rst_rdata", {p0_rdata_w[0], p1_rdata_w[0]}, 64'h0);

    // Round-robin alternation with both ports requesting; port 0 wins the first tie
    ARESETn = 1'b1;
    bridge_rdata = 32'h0BAD_F00D;
    p0_req = 1; p0_rd0_wr1 = 0; p0_addr = 32'h100;
    p1_req = 1; p1_rd0_wr1 = 0; p1_addr = 32'h200;
    for (int i = 0; i < 4; i++) push(i[0], 32'h0BAD_F00D, 2'b00);
    for (int i = 0; i < 4; i++) begin
      wait_gnt(0, i[0] ? 2'b10 : 2'b01, "rr_gnt");
      if (i == 3) begin p0_req = 0; p1_req = 0; end
    end
    wait_done(0, 2'b10, "rr_last_done");

    // Port 0 read of 0x1000
    @(negedge ACLK);
    bridge_rdata = 32'hDEAD_BEEF; bridge_resp = 2'b00;
    p0_req = 1; p0_rd0_wr1 = 0; p0_addr = 32'h1000;
    push(0, 32'hDEAD_BEEF, 2'b00);
    @(negedge ACLK);
    chk("p0_gnt_cycle1", {p1_gnt_w[0], p0_gnt_w[0], m_access[0]}, 3'b011);
    chk("p0_rd_addr", {m_rw[0], m_addr[0]}, {1'b0, 32'h1000});
    p0_req = 0;
    wait_done(0, 2'b01, "p0_rd_done");

    // Port 1 write with SLVERR response
    @(negedge ACLK);
    bridge_resp = 2'b10;
    p1_req = 1; p1_rd0_wr1 = 1; p1_addr = 32'h2004; p1_wdata = 32'h1234_5678; p1_strb = 4'hF;
    push(1, 32'h0, 2'b10);
    @(negedge ACLK);
    chk("p1_gnt_cycle1", {p1_gnt_w[0], p0_gnt_w[0], m_access[0]}, 3'b101);
    chk("p1_wr_cmd", {m_rw[0], m_addr[0], m_wdata[0], m_strb[0]}, {1'b1, 32'h2004, 32'h1234_5678, 4'hF});
    p1_req = 0;
    wait_done(0, 2'b10, "p1_wr_done");

    // Port 1 arrives during port 0's WAIT
    @(negedge ACLK);
    bridge_resp = 2'b00; bridge_rdata = 32'hCAFE_0001;
    p0_req = 1; p0_rd0_wr1 = 0; p0_addr = 32'h3000;
    push(0, 32'hCAFE_0001, 2'b00);
    wait_gnt(0, 2'b01, "late_p0_gnt");
    p0_req = 0;
    @(negedge ACLK);
    p1_req = 1; p1_rd0_wr1 = 1; p1_addr = 32'h3004; p1_wdata = 32'hA5A5_A5A5; p1_strb = 4'h3;
    push(1, 32'h0, 2'b00);
    n = 0; seen = 0;
    do begin
      @(negedge ACLK);
      n++;
      if (m_access[0]) seen = 1;
    end while (!p0_done_w[0] && n < 50);
    chk("late_no_access_before_done", {seen, p0_done_w[0]}, 2'b01);
    @(negedge ACLK);
    chk("late_p1_not_yet", {p1_gnt_w[0], m_access[0]}, 2'b00);
    @(negedge ACLK);
    chk("late_p1_gnt_2cyc", {p1_gnt_w[0], m_access[0], m_addr[0]}, {2'b11, 32'h3004});
    p1_req = 0;
    wait_done(0, 2'b10, "late_p1_done");

    // Reset in the middle of a port 0 write
    @(negedge ACLK);
    p0_req = 1; p0_rd0_wr1 = 1; p0_addr = 32'h4000; p0_wdata = 32'h5555_AAAA; p0_strb = 4'hC;
    wait_gnt(0, 2'b01, "abort_gnt");
    p0_req = 0;
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    chk("abort_ctrl_zero", {p0_gnt_w[0], p0_done_w[0], m_access[0], m_rw[0]}, 4'h0);
    chk("abort_data_zero", {m_addr[0], m_wdata[0], m_strb[0]}, 68'h0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge ACLK);
      if (p0_done_w[0] || p1_done_w[0]) n++;
    end
    chk("abort_no_done", n, 0);
    bridge_rdata = 32'h7777_1234;
    p0_req = 1; p0_rd0_wr1 = 0; p0_addr = 32'h4008;
    push(0, 32'h7777_1234, 2'b00);
    wait_gnt(0, 2'b01, "post_rst_gnt");
    p0_req = 0;
    wait_done(0, 2'b01, "post_rst_done");

    // Bridge busy while idle: no grant until ready returns
    @(negedge ACLK);
    hold_busy = 1;
    bridge_rdata = 32'h0000_BEEF;
    p0_req = 1; p0_rd0_wr1 = 0; p0_addr = 32'h5000;
    push(0, 32'h0000_BEEF, 2'b00);
    seen = 0;
    repeat (5) begin
      @(negedge ACLK);
      if (p0_gnt_w[0] || m_access[0]) seen = 1;
    end
    chk("busy_no_gnt", seen, 0);
    hold_busy = 0;
    @(negedge ACLK);
    chk("busy_gnt_after_ready", {p0_gnt_w[0], m_access[0]}, 2'b11);
    p0_req = 0;
    wait_done(0, 2'b01, "busy_done");

    // Fixed-priority instance: port 0 always wins, port 1 starves
    @(negedge ACLK);
    use_fp = 1;
    p0_req = 1; p0_rd0_wr1 = 0; p0_addr = 32'h6000;
    p1_req = 1; p1_rd0_wr1 = 0; p1_addr = 32'h6004;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(1, 2'b01, "fp_gnt");
      if (i == 2) begin p0_req = 0; p1_req = 0; end
    end
    wait_done(1, 2'b01, "fp_done");

    repeat (3) @(negedge ACLK);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
